// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM state and op encodings shared by the serial add/sub sequencer
package serial_add_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/onebit_adder.sv
// onebit_adder: full adder; in_1/in_2/c_in in, sum/c_out out
module onebit_adder (
  input  logic in_1,
  input  logic in_2,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum = in_1 ^ in_2 ^ c_in;
  assign c_out = (in_1 & in_2) | (c_in & (in_1 ^ in_2));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial add/sub; start/op_sub/a/b in, busy/done/result/c_out/overflow out
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
  logic [1:0] state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
  logic [CW-1:0] cnt;
  logic carry, carry_msb_in, sum, c;
  onebit_adder u_add (
    .in_1 (a_sr[0]),
    .in_2 (b_sr[0]),
    .c_in (carry),
    .sum  (sum),
    .c_out(c)
  );
  assign r_next = {sum, r_sr[WIDTH-1:1]};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      cnt <= '0;
      carry <= 1'b0;
      carry_msb_in <= 1'b0;
      result <= '0;
      c_out <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sr <= a;
        b_sr <= op_sub == OP_SUB ? ~b : b;
        carry <= op_sub;
        cnt <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_next;
      carry <= c;
      if (cnt == PENULT) carry_msb_in <= c;
      if (cnt == LAST) begin
        state <= DONE;
        result <= r_next;
        c_out <= c;
        overflow <= carry_msb_in ^ c;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, op_sub = 1'b0;
  logic [7:0] a = '0, b = '0, result;
  logic busy, done, c_out, overflow;
  logic start32 = 1'b0, op32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic busy32, done32, co32, ov32;
  int checks = 0;
  int errors = 0;
  int n;
  logic [65:0] exp;
  always #5 clk = ~clk;
  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow)
  );
  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op_sub(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .c_out(co32), .overflow(ov32)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [65:0] model(input int w, input logic op, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask, r;
    logic cy, sa, sb, sr, ov;
    mask = (64'd1 << w) - 64'd1;
    x &= mask;
    y &= mask;
    r = (op ? x - y : x + y) & mask;
    cy = op ? (x >= y) : ((x + y) > mask);
    sa = x[w-1];
    sb = y[w-1];
    sr = r[w-1];
    ov = op ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    return {ov, cy, r};
  endfunction
  task automatic wait_done8(output int cnt);
    cnt = 0;
    while (!done && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask
  task automatic do_op(input logic op, input logic [7:0] x, input logic [7:0] y, input string tag);
    int k;
    logic [65:0] e;
    e = model(8, op, {56'd0, x}, {56'd0, y});
    @(negedge clk);
    start = 1'b1;
    op_sub = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    op_sub = 1'($urandom);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done8(k);
    chk({tag, "_latency"}, 64'(k), 64'd8);
    chk({tag, "_result"}, {56'd0, result}, e[63:0]);
    chk({tag, "_cout_ovf"}, {62'd0, overflow, c_out}, {62'd0, e[65], e[64]});
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {52'd0, busy, done, c_out, overflow, result}, 64'd0);
    chk("reset_outputs32", {28'd0, busy32, done32, co32, ov32, res32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 8'h05, 8'h03, "add_05_03");
    chk("add_05_03_const", {54'd0, overflow, c_out, result}, {54'd0, 2'b00, 8'h08});
    do_op(1'b0, 8'hFF, 8'h01, "add_ff_01");
    chk("add_ff_01_const", {54'd0, overflow, c_out, result}, {54'd0, 2'b01, 8'h00});
    do_op(1'b0, 8'h7F, 8'h01, "add_7f_01");
    chk("add_7f_01_const", {54'd0, overflow, result}, {54'd0, 1'b1, 8'h80});
    do_op(1'b1, 8'h05, 8'h07, "sub_05_07");
    chk("sub_05_07_const", {54'd0, overflow, c_out, result}, {54'd0, 2'b00, 8'hFE});
    do_op(1'b1, 8'h80, 8'h01, "sub_80_01");
    chk("sub_80_01_const", {54'd0, overflow, result}, {54'd0, 1'b1, 8'h7F});
    @(negedge clk);
    start = 1'b1;
    op_sub = 1'b0;
    a = 8'h12;
    b = 8'h34;
    @(posedge clk);
    #1;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      op_sub = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    chk("ignore_latency", 64'(n), 64'd8);
    chk("ignore_result", {56'd0, result}, 64'h46);
    @(negedge clk);
    op_sub = 1'b1;
    a = 8'h20;
    b = 8'h01;
    @(posedge clk);
    #1;
    chk("ignore_not_in_done", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    chk("accept_after_done", {63'd0, busy}, 64'd1);
    start = 1'b0;
    wait_done8(n);
    chk("accept_after_done_latency", 64'(n), 64'd8);
    chk("accept_after_done_result", {56'd0, result}, 64'h1F);
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b1;
    op_sub = 1'b0;
    a = 8'h11;
    b = 8'h22;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {52'd0, busy, done, c_out, overflow, result}, 64'd0);
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk("abort_no_done", 64'(n), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 8'h3C, 8'h4B, "after_abort");
    for (int i = 0; i < 12; i++) do_op(1'($urandom), 8'($urandom), 8'($urandom), "rand");
    exp = model(32, 1'b0, 64'h7FFFFFFF, 64'h1);
    @(negedge clk);
    start32 = 1'b1;
    op32 = 1'b0;
    a32 = 32'h7FFFFFFF;
    b32 = 32'h00000001;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    n = 0;
    while (!done32 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w32_latency", 64'(n), 64'd32);
    chk("w32_result", {32'd0, res32}, exp[63:0]);
    chk("w32_result_const", {32'd0, res32}, 64'h80000000);
    chk("w32_ovf", {62'd0, ov32, co32}, {62'd0, exp[65], exp[64]});
    chk("w32_ovf_const", {63'd0, ov32}, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
